// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
package control_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StTrap
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, never on the FSM state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/control_alu_decoder.sv
// ALU operation decoder; flags funct3 values the ALU does not implement.
module control_alu_decoder
    import control_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_r,
    input  logic       funct7_b5,
    output logic [2:0] alu_control,
    output logic       valid
);

    // Map alu_op/funct fields to an ALU operation.
    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op_r && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: valid = 1'b0;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_multicycle.sv
// Multi-cycle RV32I control FSM with memory wait states, bus watchdog and traps.
module control_multicycle
    import control_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH  = 32,
    parameter int unsigned WAIT_TIMEOUT = 16,
    parameter int unsigned TMR_W        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   adr_src,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic [1:0]             result_src,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [2:0]             alu_control,
    output logic [1:0]             imm_src,
    output logic                   reg_write,
    output logic                   instr_done,
    output logic                   illegal_instr,
    output logic                   bus_error
);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             illegal_q, bus_error_q;
    logic [1:0]       alu_op;
    logic             funct_valid;
    logic             mem_state, timeout, illegal_set;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign unused_instr = ^{instr[INSTR_WIDTH-1:31], instr[29:15], instr[11:7]};

    control_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_r        (opcode[5]),
        .funct7_b5   (instr[30]),
        .alu_control (alu_control),
        .valid       (funct_valid)
    );

    assign imm_src = imm_src_of(opcode);

    assign mem_state = (state_q == StFetch) || (state_q == StMemRead) ||
                       (state_q == StMemWrite);
    // Trip on the wait cycle that would bring the counter up to the limit;
    // mem_ready in that same cycle still lets the access complete.
    assign timeout = (WAIT_TIMEOUT != 0) && mem_state && !mem_ready &&
                     ((wait_cnt_q + TMR_W'(1)) == TMR_W'(WAIT_TIMEOUT));

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready)    state_d = StDecode;
                else if (timeout) state_d = StTrap;
            end
            StDecode: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = StMemAdr;
                    OP_R:              state_d = StExecR;
                    OP_I:              state_d = StExecI;
                    OP_BRANCH:         state_d = (funct3[2:1] == 2'b00) ? StBranch : StTrap;
                    OP_JAL:            state_d = StJal;
                    default:           state_d = StTrap;
                endcase
            end
            StMemAdr:  state_d = opcode[5] ? StMemWrite : StMemRead;
            StMemRead: begin
                if (mem_ready)    state_d = StMemWb;
                else if (timeout) state_d = StTrap;
            end
            StMemWb: state_d = StFetch;
            StMemWrite: begin
                if (mem_ready)    state_d = StFetch;
                else if (timeout) state_d = StTrap;
            end
            StExecR, StExecI: state_d = funct_valid ? StAluWb : StTrap;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJal:    state_d = StAluWb;
            StTrap:   state_d = StTrap;
            default:  state_d = StTrap;
        endcase
    end

    assign illegal_set = (state_d == StTrap) && !timeout && (state_q != StTrap);

    // Watchdog counter: restarts on any state change, counts unanswered accesses.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)          wait_cnt_d = '0;
        else if (mem_state && !mem_ready) wait_cnt_d = wait_cnt_q + TMR_W'(1);
    end

    // State, watchdog and sticky trap flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            wait_cnt_q  <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            illegal_q   <= illegal_q | illegal_set;
            bus_error_q <= bus_error_q | timeout;
        end
    end

    assign illegal_instr = illegal_q;
    assign bus_error     = bus_error_q;

    // Per-state datapath controls; strobes are suppressed while in reset.
    always_comb begin
        mem_req    = 1'b0;
        adr_src    = ADR_PC;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_OP_ADD;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            StDecode: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            StMemAdr: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = ADR_ALUOUT;
            end
            StMemWb: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StMemWrite: begin
                mem_req    = 1'b1;
                adr_src    = ADR_ALUOUT;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            StExecR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_OP_FUNCT;
            end
            StExecI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            StAluWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALU_OP_SUB;
                instr_done = 1'b1;
                // funct3[0] inverts the condition: beq on zero, bne on not-zero.
                pc_write   = zero ^ funct3[0];
            end
            StJal: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            StTrap: ;
            default: ;
        endcase
        if (rst) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule
